// File: rtl/fir_output_buffer.sv
// rtl/fir_output_buffer.sv - decimating output FIFO behind a fixed-latency FIR filter
module fir_output_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 8,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     x_valid,
    input  logic [DATA_WIDTH-1:0]    y_in,
    input  logic [3:0]               decim,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [LATENCY-1:0]    tag_q, tag_d;
    logic                  y_tag;
    logic [3:0]            phase_q, phase_d;
    logic [3:0]            period_q, period_d;
    logic                  keep;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         level_w;
    logic                  full;
    logic                  do_pop;
    logic                  do_push;
    logic                  drop;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Delay line tracks which y_in cycles carry a real filter result; flush kills everything in flight
    generate
        if (LATENCY == 1) begin : g_tag1
            assign tag_d = flush ? '0 : x_valid;
        end else begin : g_tagn
            assign tag_d = flush ? '0 : {tag_q[LATENCY-2:0], x_valid};
        end
    endgenerate

    assign y_tag = tag_q[LATENCY-1];

    // Decimation phase: keep on phase 0, latch the period length there so mid-period decim edits wait
    always_comb begin
        phase_d  = phase_q;
        period_d = period_q;
        keep     = 1'b0;
        if (y_tag) begin
            if (phase_q == 4'd0) begin
                keep     = 1'b1;
                period_d = decim;
                phase_d  = (decim == 4'd0) ? 4'd0 : 4'd1;
            end else begin
                phase_d = (phase_q == period_q) ? 4'd0 : phase_q + 4'd1;
            end
        end
        if (flush) begin
            keep    = 1'b0;
            phase_d = 4'd0;
        end
    end

    assign level_w   = wr_ptr_q - rd_ptr_q;
    assign full      = (level_w == PW'(DEPTH));
    assign out_valid = (level_w != '0);
    assign do_pop    = out_valid && out_ready && !flush;
    assign do_push   = keep && (!full || do_pop);
    assign drop      = keep && full && !do_pop;

    // Pointer and sticky-overflow next state; flush empties the FIFO by snapping read onto write
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q | drop;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q      <= '0;
            phase_q    <= 4'd0;
            period_q   <= 4'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            tag_q      <= tag_d;
            phase_q    <= phase_d;
            period_q   <= period_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Sample storage; cleared on reset so out_data reads zero while held in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= y_in;
        end
    end

    assign out_data = mem_q[rd_ptr_q[AW-1:0]];
    assign level    = level_w;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fir_output_buffer.sv
// tb/tb_fir_output_buffer.sv - randomized self-checking bench for fir_output_buffer
module tb_fir_output_buffer;

    localparam int DW    = 16;
    localparam int LAT   = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          x_valid = 1'b0;
    logic [DW-1:0] y_in = '0;
    logic [3:0]    decim = '0;
    logic          flush = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    level;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    int npops  = 0;

    // Reference model: x_valid history, position within the current keep period, FIFO contents
    bit          mhist[$];
    int          mcnt;
    int          mperiod;
    logic [DW-1:0] mq[$];
    bit          movf;

    fir_output_buffer #(.DATA_WIDTH(DW), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .y_in(y_in), .decim(decim),
        .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mhist.delete();
        for (int i = 0; i < LAT; i++) mhist.push_back(1'b0);
        mcnt = 0;
        mperiod = 1;
        mq.delete();
        movf = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model at the edge, return at the following negedge
    task automatic cycle(input bit v, input logic [DW-1:0] y, input logic [3:0] d, input bit f, input bit r);
        bit tag;
        bit keep;
        x_valid = v; y_in = y; decim = d; flush = f; out_ready = r;
        @(posedge clk);
        tag = mhist.pop_front();
        mhist.push_back(f ? 1'b0 : v);
        if (f) begin
            mq.delete();
            for (int i = 0; i < LAT; i++) mhist[i] = 1'b0;
            mcnt = 0;
        end else begin
            keep = tag && (mcnt == 0);
            if (tag) begin
                if (mcnt == 0) mperiod = int'(d) + 1;
                mcnt = (mcnt + 1) % mperiod;
            end
            if (mq.size() > 0 && r) begin
                void'(mq.pop_front());
                npops++;
            end
            if (keep) begin
                if (mq.size() < DEPTH) mq.push_back(y);
                else movf = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; x_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; decim = '0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", out_data); end
    endtask

    task automatic test_decim0(input string tag);
        int first;
        logic [DW-1:0] got[$];
        first = -1;
        for (int k = 0; k < 16; k++) begin
            cycle(k < 4, 16'h0011 + 16'(k), 4'd0, 1'b0, 1'b1);
            if (out_valid === 1'b1) begin
                if (first < 0) first = k + 1;
                got.push_back(out_data);
            end
            checks++; if (level !== 4'(mq.size())) begin errors++; $display("FAIL %s_level c%0d got %0d exp %0d", tag, k + 1, level, mq.size()); end
            checks++; if (out_valid === 1'b1 && out_data !== mq[0]) begin errors++; $display("FAIL %s_data c%0d got %h exp %h", tag, k + 1, out_data, mq[0]); end
        end
        checks++; if (first != LAT + 1) begin errors++; $display("FAIL %s_first_valid got %0d exp %0d", tag, first, LAT + 1); end
        checks++;
        if (got.size() != 4) begin
            errors++; $display("FAIL %s_count got %0d exp 4", tag, got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (got[i] !== 16'h0011 + 16'(8 + i)) begin errors++; $display("FAIL %s_order[%0d] got %h exp %h", tag, i, got[i], 16'h0011 + 16'(8 + i)); end
            end
        end
    endtask

    task automatic test_decim2();
        int p0;
        do_reset();
        p0 = npops;
        for (int k = 0; k < 32; k++) begin
            cycle(k < 12, 16'($urandom), 4'd2, 1'b0, 1'b1);
            checks++; if (out_valid === 1'b1 && out_data !== mq[0]) begin errors++; $display("FAIL decim2_data c%0d got %h exp %h", k + 1, out_data, mq[0]); end
            checks++; if (level !== 4'(mq.size())) begin errors++; $display("FAIL decim2_level c%0d got %0d exp %0d", k + 1, level, mq.size()); end
        end
        checks++; if (npops - p0 != 4) begin errors++; $display("FAIL decim2_outputs got %0d exp 4", npops - p0); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            cycle(k < 10, 16'($urandom), 4'd0, 1'b0, 1'b0);
            checks++; if (overflow !== movf) begin errors++; $display("FAIL ovf_flag c%0d got %b exp %b", k + 1, overflow, movf); end
            checks++; if (level !== 4'(mq.size())) begin errors++; $display("FAIL ovf_level c%0d got %0d exp %0d", k + 1, level, mq.size()); end
        end
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_saturate got %0d exp 8", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        for (int k = 0; k < 10; k++) begin
            checks++; if (out_valid === 1'b1 && out_data !== mq[0]) begin errors++; $display("FAIL ovf_drain_data got %h exp %h", out_data, mq[0]); end
            cycle(1'b0, 16'($urandom), 4'd0, 1'b0, 1'b1);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        int p0;
        for (int k = 0; k < 14; k++)
            cycle((k < 5) || (k >= 10 && k < 13), 16'($urandom), 4'd0, 1'b0, 1'b0);
        checks++; if (level !== 4'd5) begin errors++; $display("FAIL flush_pre_level got %0d exp 5", level); end
        cycle(1'b0, 16'($urandom), 4'd0, 1'b1, 1'b1);
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL flush_level got %0d exp 0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
        p0 = npops;
        for (int k = 0; k < 15; k++) begin
            cycle(1'b0, 16'($urandom), 4'd0, 1'b0, 1'b1);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_inflight c%0d got %b exp 0", k, out_valid); end
        end
        checks++; if (npops != p0) begin errors++; $display("FAIL flush_model_pops got %0d exp %0d", npops, p0); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_ovf_kept got %b exp 1", overflow); end
    endtask

    task automatic test_full_stream();
        do_reset();
        for (int k = 0; k < 45; k++) begin
            cycle(k < 28, 16'($urandom), 4'd0, 1'b0, k >= 16);
            checks++; if (out_valid === 1'b1 && out_data !== mq[0]) begin errors++; $display("FAIL full_data c%0d got %h exp %h", k + 1, out_data, mq[0]); end
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf c%0d got %b exp 0", k + 1, overflow); end
            if (k >= 16 && k <= 35) begin
                checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_level c%0d got %0d exp 8", k + 1, level); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int k = 0; k < 14; k++)
            cycle(1'($urandom), 16'($urandom), 4'($urandom_range(0, 2)), 1'b0, 1'($urandom));
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL midrst_level got %0d exp 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b exp 0", overflow); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL midrst_data got %h exp 0000", out_data); end
        model_reset();
        #1 rst_n = 1'b1;
        test_decim0("recover");
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom), 16'($urandom),
                  ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3)),
                  $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0);
            checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", k, out_valid, mq.size() > 0); end
            checks++; if (level !== 4'(mq.size())) begin errors++; $display("FAIL rnd_level c%0d got %0d exp %0d", k, level, mq.size()); end
            checks++; if (overflow !== movf) begin errors++; $display("FAIL rnd_ovf c%0d got %b exp %b", k, overflow, movf); end
            if (mq.size() > 0) begin
                checks++; if (out_data !== mq[0]) begin errors++; $display("FAIL rnd_data c%0d got %h exp %h", k, out_data, mq[0]); end
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_decim0("decim0");
        test_decim2();
        test_overflow();
        test_flush();
        test_full_stream();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_output_buffer.md
FIR_OUTPUT_BUFFER -- requirements
Module: fir_output_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of filter output samples.
REQ-002 Parameter LATENCY, default 8: cycles from sample entering filter to its result on y_in (2*TAPS for TAPS=4).
REQ-003 Parameter DEPTH, default 8: FIFO entries, power of two, >= 2.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 x_valid  input  1  high in the cycle a valid sample is presented to the filter input.
REQ-007 y_in  input  DATA_WIDTH  filter output, sampled every cycle.
REQ-008 decim  input  4  decimation factor minus one (0 = keep every sample, 15 = keep 1 of 16).
REQ-009 flush  input  1  synchronous pulse: empty FIFO, clear decimation phase and in-flight valids.
REQ-010 out_data  output  DATA_WIDTH  FIFO head sample.
REQ-011 out_valid  output  1  FIFO non-empty.
REQ-012 out_ready  input  1  downstream accept; transfer when out_valid && out_ready.
REQ-013 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 overflow  output  1  sticky: a kept sample was dropped because FIFO was full.

Function
REQ-015 A LATENCY-deep shift register SHALL delay x_valid; its last stage (y_tag) marks y_in as a valid filter result in that cycle.
REQ-016 Phase counter SHALL advance only on y_tag cycles: sample kept when phase==0; phase wraps from decim to 0.
REQ-017 decim SHALL be sampled only when phase==0 on a y_tag cycle; changes mid-period take effect at next period.
REQ-018 Kept sample SHALL be written to FIFO tail in the same clock edge (push latency: visible on out_valid one cycle after y_tag cycle when empty).
REQ-019 out_data SHALL present the head entry combinationally from storage; order strictly FIFO.
REQ-020 Pop SHALL occur on out_valid && out_ready; no pop when empty regardless of out_ready.
REQ-021 Push when full and no pop in same cycle: sample discarded, overflow set, FIFO contents unchanged.
REQ-022 Push when full with simultaneous pop: both occur, level unchanged, no overflow.
REQ-023 Push and pop when level==1: both occur, level stays 1, new sample becomes head.
REQ-024 Read/write pointers SHALL be $clog2(DEPTH)+1 bits, wrapping naturally; level = wr_ptr - rd_ptr.
REQ-025 flush SHALL take priority over push/pop in its cycle: pointers equalised, level 0, phase 0, delay line cleared; overflow NOT cleared.
REQ-026 overflow SHALL clear only on reset.
REQ-027 y_in on non-tag cycles SHALL be ignored entirely.

Reset
REQ-028 On rst_n low, asynchronously: delay line 0, phase 0, pointers 0, level 0, out_valid 0, overflow 0.
REQ-029 out_data SHALL be 0 during reset (storage cleared); FIFO storage otherwise holds data after reset release.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight and buffered samples; no output transfer in the first cycle after release.

Verification
REQ-031 decim=0, x_valid high cycles 0-3, y_in=0x0011+cycle, out_ready=1 -> out_valid first high at cycle LATENCY+1, outputs y_in values from cycles 8,9,10,11 in order.
REQ-032 decim=2, x_valid held high 12 cycles, out_ready=1 -> exactly 4 outputs, from tag cycles 0,3,6,9 of the tag stream.
REQ-033 out_ready=0, decim=0, 10 valid samples -> level saturates at 8, overflow=1 after ninth push, first 8 samples retained and drained in order once out_ready=1.
REQ-034 FIFO full, out_ready=1 while push continues -> level stays 8, overflow stays 0, ordering intact over 20 samples.
REQ-035 flush asserted with level=5 and 3 samples in delay line -> level 0, out_valid 0 next cycle, no outputs from those 3 samples, overflow unchanged.
REQ-036 rst_n pulsed low for a partial cycle mid-stream -> all outputs at reset values immediately, recovery with fresh x_valid reproduces REQ-031 timing.
